// File: rtl/sequence_gen_tx_if.sv
// Purpose: bundles the control, pattern and serial-output signals of sequence_gen_tx.
// Latency: none (wires only).
// Backpressure: none; the transmitter is start/busy/done handshaked, never stalled by the sink.
//
// Signals
//   start       request, honoured only while busy=0
//   abort       cancel the transfer in progress
//   pattern     PAT_W-bit pattern, sent MSB first
//   repeat_cnt  number of frames minus one
//   gap         idle cycles between frames
//   data        serial bit out
//   valid       data carries a pattern (or parity) bit
//   busy        transfer in progress
//   done        one-cycle pulse when the last frame has finished
// Modports: master = requester/sink side, slave = transmitter side.
interface sequence_gen_tx_if #(
    parameter int PAT_W = 4,
    parameter int RPT_W = 4,
    parameter int GAP_W = 4
) ();
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [RPT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap;
    logic             data;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, repeat_cnt, gap,
        input  data, valid, busy, done
    );

    modport slave (
        input  start, abort, pattern, repeat_cnt, gap,
        output data, valid, busy, done
    );
endinterface

// File: rtl/sequence_gen_tx.sv
// Purpose: serial pattern transmitter, PAT_W-bit pattern MSB first, (repeat_cnt+1) frames with idle gaps.
// Latency: first bit is visible the cycle after start is sampled; one bit per clock thereafter.
// Backpressure: none; start is ignored while busy, abort cancels on the next edge.
//
// Ports
//   clk   clock, all logic on posedge
//   rst   asynchronous active-high reset
//   bus   sequence_gen_tx_if.slave (start/abort/pattern/repeat_cnt/gap in, data/valid/busy/done out)
// Build option: define SEQ_TX_PARITY_EN to append one even-parity bit (XOR of pattern) to every
//   frame; without it no parity state or logic is built and frames are PAT_W bits long.
module sequence_gen_tx #(
    parameter int PAT_W = 4,
    parameter int RPT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    sequence_gen_tx_if.slave bus
);
    localparam int CNT_W = $clog2(PAT_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAT_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
`ifdef SEQ_TX_PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'b10;
`endif
    localparam logic [1:0] ST_GAP   = 2'b11;

    logic [1:0]       state;
    logic [PAT_W-1:0] pat_q;        // pattern held for reloading each frame
    logic [PAT_W-1:0] shreg;        // remaining bits of the current frame, MSB next
    logic [CNT_W-1:0] bit_cnt;      // index of the bit currently on data
    logic [RPT_W-1:0] frames_left;  // frames still to send after the current one
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;      // gap cycles remaining after the current one
    logic             data_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    // eof: the final cycle of a frame (last pattern bit, or parity bit) is on the output now.
    // reload: the next edge must present the MSB of a new frame.
    logic eof;
    logic reload;

    always_comb begin
        eof    = 1'b0;
        reload = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        eof = (state == ST_PAR);
`else
        eof = (state == ST_SHIFT) && (bit_cnt == LAST_BIT);
`endif
        reload = (eof && (frames_left != '0) && (gap_q == '0)) ||
                 ((state == ST_GAP) && (gap_cnt == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pat_q       <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            frames_left <= '0;
            gap_q       <= '0;
            gap_cnt     <= '0;
            data_q      <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                // Abort wins over start and over every in-flight action; done is not raised.
                state   <= ST_IDLE;
                data_q  <= 1'b0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                if (eof && (frames_left != '0))
                    frames_left <= frames_left - 1'b1;

                if (reload) begin
                    state   <= ST_SHIFT;
                    data_q  <= pat_q[PAT_W-1];
                    shreg   <= {pat_q[PAT_W-2:0], 1'b0};
                    bit_cnt <= '0;
                    valid_q <= 1'b1;
                end else if (eof) begin
                    if (frames_left == '0) begin
                        state   <= ST_IDLE;
                        data_q  <= 1'b0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        // gap_q is nonzero here, otherwise reload would have fired.
                        state   <= ST_GAP;
                        gap_cnt <= gap_q - 1'b1;
                        data_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (bus.start) begin
                                pat_q       <= bus.pattern;
                                frames_left <= bus.repeat_cnt;
                                gap_q       <= bus.gap;
                                data_q      <= bus.pattern[PAT_W-1];
                                shreg       <= {bus.pattern[PAT_W-2:0], 1'b0};
                                bit_cnt     <= '0;
                                valid_q     <= 1'b1;
                                busy_q      <= 1'b1;
                                state       <= ST_SHIFT;
                            end
                        end
                        ST_SHIFT: begin
`ifdef SEQ_TX_PARITY_EN
                            if (bit_cnt == LAST_BIT) begin
                                state  <= ST_PAR;
                                data_q <= ^pat_q;
                            end else begin
                                data_q  <= shreg[PAT_W-1];
                                shreg   <= {shreg[PAT_W-2:0], 1'b0};
                                bit_cnt <= bit_cnt + 1'b1;
                            end
`else
                            data_q  <= shreg[PAT_W-1];
                            shreg   <= {shreg[PAT_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
`endif
                        end
`ifdef SEQ_TX_PARITY_EN
                        ST_PAR: begin
                            // Always handled as eof above.
                        end
`endif
                        ST_GAP: begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                        default: begin
                            state   <= ST_IDLE;
                            data_q  <= 1'b0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_sequence_gen_tx.sv
// Purpose: self-checking bench for sequence_gen_tx (directed cases plus randomized transfers).
// Latency: expected per-cycle output records are queued when a start is accepted.
// Backpressure: none; a monitor pops one record per cycle while transfers are outstanding.
module tb_sequence_gen_tx;
    localparam int PAT_W = 4;
    localparam int RPT_W = 4;
    localparam int GAP_W = 4;

    // Packed output record: {valid, data, busy, done}
    typedef logic [3:0] rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sequence_gen_tx_if #(.PAT_W(PAT_W), .RPT_W(RPT_W), .GAP_W(GAP_W)) bus ();

    sequence_gen_tx #(.PAT_W(PAT_W), .RPT_W(RPT_W), .GAP_W(GAP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input rec_t got, input rec_t req);
        n_checks++;
        if (got === req) n_pass++;
        else $display("FAIL %s: got v/d/busy/done=%b required %b at %0t", name, got, req, $time);
    endtask

    // Reference model: the full cycle-by-cycle output of one transfer, straight from the frame rules.
    task automatic push_transfer(input logic [PAT_W-1:0] p, input logic [RPT_W-1:0] r,
                                 input logic [GAP_W-1:0] g);
        for (int f = 0; f <= int'(r); f++) begin
            for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({1'b1, p[b], 1'b1, 1'b0});
`ifdef SEQ_TX_PARITY_EN
            exp_q.push_back({1'b1, ^p, 1'b1, 1'b0});
`endif
            if (f < int'(r))
                for (int k = 0; k < int'(g); k++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
    endtask

    // One clock of stimulus; the model sees exactly what the DUT samples at this edge.
    task automatic step(input logic s, input logic a, input logic [PAT_W-1:0] p,
                        input logic [RPT_W-1:0] r, input logic [GAP_W-1:0] g);
        bus.start      = s;
        bus.abort      = a;
        bus.pattern    = p;
        bus.repeat_cnt = r;
        bus.gap        = g;
        @(posedge clk);
        if (a) exp_q.delete();
        else if (s && exp_q.size() == 0) push_transfer(p, r, g);
        #1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        // Scramble inputs so a transfer that re-reads them would be caught.
        bus.pattern    = PAT_W'($urandom());
        bus.repeat_cnt = RPT_W'($urandom());
        bus.gap        = GAP_W'($urandom());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0);
    endtask

    // Runs until the model has drained, optionally firing ignored starts; bounded.
    task automatic drain(input bit noisy);
        int budget;
        budget = 0;
        while (exp_q.size() != 0) begin
            if (budget > 600) begin
                n_checks++;
                $display("FAIL drain_timeout: %0d records left, required 0", exp_q.size());
                exp_q.delete();
                break;
            end
            step(noisy && ($urandom_range(3, 0) == 0), 1'b0, PAT_W'($urandom()),
                 RPT_W'($urandom()), GAP_W'($urandom()));
            budget++;
        end
    endtask

    // Monitor: one record per cycle while a transfer is expected, else the DUT must be idle.
    always @(negedge clk) begin
        rec_t got;
        got = {bus.valid, bus.data, bus.busy, bus.done};
        if (exp_q.size() != 0) chk("stream", got, exp_q.pop_front());
        else                   chk("idle", got, 4'b0000);
    end

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.pattern = '0; bus.repeat_cnt = '0; bus.gap = '0;
        #2;
        chk("reset_outputs", {bus.valid, bus.data, bus.busy, bus.done}, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Single frame, then two frames with gap 2, then 3 frames back-to-back with ignored starts.
        step(1'b1, 1'b0, 4'b1011, 4'd0, 4'd0); drain(1'b0);
        step(1'b1, 1'b0, 4'b1011, 4'd1, 4'd2); drain(1'b0);
        step(1'b1, 1'b0, 4'b1011, 4'd2, 4'd0); drain(1'b1);
        step(1'b1, 1'b0, 4'b1001, 4'd0, 4'd1); drain(1'b0);

        // Abort at cycle 2.
        step(1'b1, 1'b0, 4'b1011, 4'd0, 4'd0);
        idle(1);
        step(1'b0, 1'b1, '0, '0, '0);
        idle(3);

        // Start and abort together in idle: abort wins.
        step(1'b1, 1'b1, 4'b1111, 4'd0, 4'd0);
        idle(2);

        // Start on the same edge that the done pulse is visible.
        step(1'b1, 1'b0, 4'b0110, 4'd0, 4'd0); drain(1'b0);
        step(1'b1, 1'b0, 4'b1100, 4'd1, 4'd1); drain(1'b0);

        // Full repeat count: 2**RPT_W frames.
        step(1'b1, 1'b0, 4'b0101, 4'hF, 4'd0); drain(1'b0);

        // Reset mid-gap: outputs drop at once, next start begins cleanly.
        step(1'b1, 1'b0, 4'b1011, 4'd1, 4'd3);
        idle(5);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("reset_mid_gap", {bus.valid, bus.data, bus.busy, bus.done}, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b1, 1'b0, 4'b1011, 4'd0, 4'd0); drain(1'b0);

        // Randomized transfers with ignored starts and occasional aborts.
        for (int t = 0; t < 30; t++) begin
            int budget;
            step(1'b1, 1'b0, PAT_W'($urandom()), RPT_W'($urandom_range(3, 0)),
                 GAP_W'($urandom_range(3, 0)));
            budget = 0;
            while (exp_q.size() != 0 && budget < 600) begin
                step($urandom_range(7, 0) == 0, $urandom_range(40, 0) == 0,
                     PAT_W'($urandom()), RPT_W'($urandom()), GAP_W'($urandom()));
                budget++;
            end
            if (exp_q.size() != 0) begin
                n_checks++;
                $display("FAIL random_timeout: %0d records left, required 0", exp_q.size());
                exp_q.delete();
            end
            idle($urandom_range(2, 0));
        end

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
